// File: rtl/ysyx_24090013_instrom_pkg.sv
// Shared definitions for the instruction-ROM responder: FSM encoding,
// default constants and the address range check used by fetch and load paths.
package ysyx_24090013_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEF_NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;

    // off is (addr - base); with a word-aligned base its low bits equal the
    // address low bits. Anything at or beyond 2^(aw+2) bytes is out of range,
    // which also catches addresses below base (they wrap to huge offsets).
    function automatic logic range_fault(input logic [31:0] off, input int unsigned aw);
        return (off[1:0] != 2'b00) || ((off >> (aw + 32'd2)) != 32'd0);
    endfunction

endpackage

// File: rtl/ysyx_24090013_instrom_sram1r1w.sv
// Synchronous 1-read/1-write word array. A read and a write to the same word
// in one cycle return the old contents (read-before-write). Not reset.
module ysyx_24090013_sram1r1w #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem_r [DEPTH];

    // Registered read and write port; the NBA ordering gives read-before-write.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/ysyx_24090013_instrom.sv
// Instruction-memory responder: accepts fetches when not busy, reads the word
// at acceptance, and presents it with a one-cycle valid strobe LATENCY cycles
// later. A separate load port fills the array at any time.
module ysyx_24090013_instrom
    import ysyx_24090013_defs::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] NOP_INST    = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        openmips_instrom_ren,
    input  logic [31:0] openmips_instrom_addr,
    output logic [31:0] instrom_openmips_data,
    output logic        instrom_openmips_valid,
    output logic        instrom_openmips_err,
    output logic        instrom_openmips_busy,
    input  logic        load_wen,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t        state_r, state_s;
    logic [2:0]    cnt_r, cnt_s;
    logic          accept_s;
    logic          err_r;
    logic [31:0]   hold_r;
    logic [31:0]   req_off_s, ld_off_s;
    logic          req_err_s, ld_err_s;
    logic [AW-1:0] req_idx_s, ld_idx_s;
    logic          ram_re_s, ram_we_s;
    logic [31:0]   ram_rdata_s;
    logic          valid_s;
    logic [31:0]   resp_data_s;

    // Decode fetch and load addresses into word index plus fault flag.
    always_comb begin
        req_off_s = openmips_instrom_addr - BASE_ADDR;
        req_err_s = range_fault(req_off_s, AW);
        req_idx_s = req_off_s[AW+1:2];
        ld_off_s  = load_addr - BASE_ADDR;
        ld_err_s  = range_fault(ld_off_s, AW);
        ld_idx_s  = ld_off_s[AW+1:2];
        ram_re_s  = accept_s && !rst;
        ram_we_s  = load_wen && !ld_err_s;
    end

    // Next-state logic: accept in IDLE/RESP, count down the wait in WAIT.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE, RESP: begin
                if (openmips_instrom_ren) begin
                    accept_s = 1'b1;
                    cnt_s    = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                    cnt_s   = 3'd0;
                end
            end
            WAIT: begin
                cnt_s = cnt_r - 3'd1;
                if (cnt_r <= 3'd1) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State, counter, captured error flag and held output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            err_r   <= 1'b0;
            hold_r  <= NOP_INST;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                err_r <= req_err_s;
            end
            if (valid_s) begin
                hold_r <= resp_data_s;
            end
        end
    end

    // Output mux: the response word during RESP, the last word otherwise.
    // Reset suppresses a pending pulse in the cycle it is asserted.
    always_comb begin
        valid_s = (state_r == RESP) && !rst;
        if (err_r) begin
            resp_data_s = 32'h0000_0000;
        end else begin
            resp_data_s = ram_rdata_s;
        end
        if (valid_s) begin
            instrom_openmips_data = resp_data_s;
        end else begin
            instrom_openmips_data = hold_r;
        end
        instrom_openmips_valid = valid_s;
        instrom_openmips_err   = valid_s && err_r;
        instrom_openmips_busy  = (state_r == WAIT);
    end

    ysyx_24090013_sram1r1w #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .re    (ram_re_s),
        .raddr (req_idx_s),
        .rdata (ram_rdata_s),
        .we    (ram_we_s),
        .waddr (ld_idx_s),
        .wdata (load_wdata)
    );

endmodule

// File: tb/tb_ysyx_24090013_instrom.sv
// Bench for the instruction-ROM responder: three instances (latency 1, 3, 4)
// share clock, reset and load port; a timestamp-based model predicts every
// output each cycle, and directed steps pin literal expectations.
module tb_ysyx_24090013_instrom;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          NI    = 3;
    localparam int          LATS [NI] = '{1, 3, 4};

    logic        clk;
    logic        rst;
    logic        ren   [NI];
    logic [31:0] addr  [NI];
    logic [31:0] data  [NI];
    logic        valid [NI];
    logic        err   [NI];
    logic        busy  [NI];
    logic        load_wen;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // model state: at most one response pending per instance
    bit          pend       [NI];
    int          due        [NI];
    logic [31:0] pdata      [NI];
    bit          perr       [NI];
    bit          pknown     [NI];
    int          busy_until [NI];
    logic [31:0] last_data  [NI];
    bit          last_known [NI];
    logic [31:0] mem_m [int];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ysyx_24090013_instrom #(
            .BASE_ADDR   (BASE),
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (LATS[g]),
            .NOP_INST    (NOP)
        ) u_dut (
            .clk                    (clk),
            .rst                    (rst),
            .openmips_instrom_ren   (ren[g]),
            .openmips_instrom_addr  (addr[g]),
            .instrom_openmips_data  (data[g]),
            .instrom_openmips_valid (valid[g]),
            .instrom_openmips_err   (err[g]),
            .instrom_openmips_busy  (busy[g]),
            .load_wen               (load_wen),
            .load_addr              (load_addr),
            .load_wdata             (load_wdata)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(1, 3));
            1: a = BASE - 32'($urandom_range(1, 64) * 4);
            2: a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
            3: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            default: a = BASE + 32'($urandom_range(0, 31) * 4);
        endcase
        return a;
    endfunction

    // Per-cycle comparison against the model, then advance the model with
    // this cycle's inputs (fetches snapshot memory before this cycle's load).
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int i = 0; i < NI; i++) begin
                    bit          ev;
                    bit          ee;
                    bit          eb;
                    bit          dk;
                    logic [31:0] ed;
                    logic [31:0] off;
                    ev = !rst && pend[i] && (due[i] == cyc);
                    ee = ev && perr[i];
                    eb = (cyc <= busy_until[i]);
                    if (ev) begin
                        ed = perr[i] ? 32'h0 : pdata[i];
                        dk = perr[i] || pknown[i];
                    end else begin
                        ed = last_data[i];
                        dk = last_known[i];
                    end
                    chk($sformatf("valid%0d", i), {31'd0, valid[i]}, {31'd0, ev});
                    chk($sformatf("err%0d", i),   {31'd0, err[i]},   {31'd0, ee});
                    chk($sformatf("busy%0d", i),  {31'd0, busy[i]},  {31'd0, eb});
                    if (dk) chk($sformatf("data%0d", i), data[i], ed);
                    if (ev) begin
                        last_data[i]  = ed;
                        last_known[i] = dk;
                    end
                    if (pend[i] && due[i] <= cyc) pend[i] = 1'b0;
                    if (rst) begin
                        pend[i]       = 1'b0;
                        busy_until[i] = cyc;
                        last_data[i]  = NOP;
                        last_known[i] = 1'b1;
                    end else if (ren[i] && cyc > busy_until[i]) begin
                        off           = addr[i] - BASE;
                        pend[i]       = 1'b1;
                        due[i]        = cyc + LATS[i];
                        perr[i]       = addr_bad(addr[i]);
                        pknown[i]     = mem_m.exists(int'(off >> 2));
                        pdata[i]      = pknown[i] ? mem_m[int'(off >> 2)] : 32'h0;
                        busy_until[i] = cyc + LATS[i] - 1;
                    end
                end
                if (load_wen && !addr_bad(load_addr)) begin
                    mem_m[int'((load_addr - BASE) >> 2)] = load_wdata;
                end
            end
            cyc++;
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_wen = 1'b1; load_addr = a; load_wdata = d;
        tick();
        load_wen = 1'b0;
    endtask

    initial begin
        logic [31:0] erra [3];
        rst = 1'b1; load_wen = 1'b0; load_addr = 32'h0; load_wdata = 32'h0;
        for (int i = 0; i < NI; i++) begin
            ren[i] = 1'b0; addr[i] = 32'h0;
            pend[i] = 1'b0; busy_until[i] = -1; last_data[i] = NOP; last_known[i] = 1'b1;
        end
        tick(); tick();
        // reset values
        for (int i = 0; i < NI; i++) begin
            chk("rst_data",  data[i], 32'h0000_0013);
            chk("rst_valid", {31'd0, valid[i]}, 32'd0);
            chk("rst_busy",  {31'd0, busy[i]}, 32'd0);
            chk("rst_err",   {31'd0, err[i]}, 32'd0);
        end
        rst = 1'b0;
        started = 1'b1;
        // fill the whole array
        for (int w = 0; w < DEPTH; w++) begin
            load_wen = 1'b1; load_addr = BASE + 32'(w * 4); load_wdata = $urandom();
            tick();
        end
        load_wen = 1'b0;

        // latency 1: load then fetch
        load(32'h8000_0004, 32'h0010_0093);
        ren[0] = 1'b1; addr[0] = 32'h8000_0004;
        tick();
        ren[0] = 1'b0;
        chk("l1_valid", {31'd0, valid[0]}, 32'd1);
        chk("l1_data", data[0], 32'h0010_0093);
        chk("l1_err", {31'd0, err[0]}, 32'd0);
        tick();

        // last word in range
        load(BASE + 32'(DEPTH * 4 - 4), 32'hCAFE_F00D);
        ren[0] = 1'b1; addr[0] = BASE + 32'(DEPTH * 4 - 4);
        tick();
        ren[0] = 1'b0;
        chk("top_err", {31'd0, err[0]}, 32'd0);
        chk("top_data", data[0], 32'hCAFE_F00D);
        tick();

        // error fetches
        erra[0] = 32'h8000_0002; erra[1] = 32'h7FFF_FFFC; erra[2] = BASE + 32'(DEPTH * 4);
        for (int k = 0; k < 3; k++) begin
            ren[0] = 1'b1; addr[0] = erra[k];
            tick();
            ren[0] = 1'b0;
            chk("e_valid", {31'd0, valid[0]}, 32'd1);
            chk("e_err", {31'd0, err[0]}, 32'd1);
            chk("e_data", data[0], 32'h0);
            tick();
        end

        // collision: write in the acceptance cycle returns old word
        load(32'h8000_0010, 32'h1234_5678);
        ren[0] = 1'b1; addr[0] = 32'h8000_0010;
        load_wen = 1'b1; load_addr = 32'h8000_0010; load_wdata = 32'hDEAD_BEEF;
        tick();
        load_wen = 1'b0;
        chk("col_old", data[0], 32'h1234_5678);
        tick();
        ren[0] = 1'b0;
        chk("col_new", data[0], 32'hDEAD_BEEF);
        tick();

        // latency 3 back to back
        load(32'h8000_0000, 32'hAAAA_0001);
        load(32'h8000_0008, 32'hAAAA_0003);
        ren[1] = 1'b1; addr[1] = 32'h8000_0000;
        tick();
        addr[1] = 32'h8000_0008;
        chk("l3_busy1", {31'd0, busy[1]}, 32'd1);
        chk("l3_nv1", {31'd0, valid[1]}, 32'd0);
        tick();
        chk("l3_busy2", {31'd0, busy[1]}, 32'd1);
        tick();
        chk("l3_free", {31'd0, busy[1]}, 32'd0);
        chk("l3_v1", {31'd0, valid[1]}, 32'd1);
        chk("l3_d1", data[1], 32'hAAAA_0001);
        tick();
        ren[1] = 1'b0;
        chk("l3_busy3", {31'd0, busy[1]}, 32'd1);
        chk("l3_nv2", {31'd0, valid[1]}, 32'd0);
        tick();
        chk("l3_busy4", {31'd0, busy[1]}, 32'd1);
        tick();
        chk("l3_v2", {31'd0, valid[1]}, 32'd1);
        chk("l3_d2", data[1], 32'hAAAA_0003);
        tick();

        // latency 4, reset two cycles after acceptance
        ren[2] = 1'b1; addr[2] = 32'h8000_0008;
        tick();
        ren[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("mr_valid", {31'd0, valid[2]}, 32'd0);
        chk("mr_busy", {31'd0, busy[2]}, 32'd0);
        chk("mr_err", {31'd0, err[2]}, 32'd0);
        chk("mr_data", data[2], NOP);
        ren[2] = 1'b1; addr[2] = 32'h8000_0000;
        tick();
        ren[2] = 1'b0;
        tick(); tick(); tick();
        chk("mr_v", {31'd0, valid[2]}, 32'd1);
        chk("mr_d", data[2], 32'hAAAA_0001);
        tick();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NI; i++) begin
                ren[i]  = ($urandom_range(0, 2) != 0);
                addr[i] = rand_addr();
            end
            load_wen   = ($urandom_range(0, 3) == 0);
            load_addr  = rand_addr();
            load_wdata = $urandom();
            tick();
        end
        rst = 1'b0; load_wen = 1'b0;
        for (int i = 0; i < NI; i++) ren[i] = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
